// File: rtl/sipo_receiver.sv
// Serial-in, parallel-out receiver: assembles N LSB-first bits into a word and
// holds it under a Valid/Ack handshake, with a sticky overrun flag.
module sipo_receiver #(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic         En,
  input  logic         w,
  input  logic         Ack,
  output logic [N-1:0] Q,
  output logic         Valid,
  output logic         Busy,
  output logic         Overrun
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   shifted;

  assign shifted = {w, sreg[N-1:1]};

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      Q       <= '0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RECV;
            Busy  <= 1'b1;
            cnt   <= '0;
            sreg  <= '0;
          end
        end
        RECV: begin
          if (Start) begin
            // A fresh Start abandons the partial frame; not an error.
            cnt  <= '0;
            sreg <= '0;
          end else if (En) begin
            sreg <= shifted;
            if (cnt == LAST) begin
              Q     <= shifted;
              Valid <= 1'b1;
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (Ack) begin
            Valid <= 1'b0;
            if (Start) begin
              state <= RECV;
              cnt   <= '0;
              sreg  <= '0;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else if (Start) begin
            // Producer started a new frame before the held word was taken.
            Overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: a bit-queue model is compared against the DUT
// every cycle, plus literal expectations taken from hand-worked frames.
module tb_sipo_receiver;

  localparam int N = 4;

  logic         clk;
  logic         rstn, start, en, w, ack;
  logic [N-1:0] q;
  logic         valid, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;

  // Model: collected bits as a list, plus frame/hold flags.
  bit           m_rx, m_hold, m_valid, m_ovr;
  bit [N-1:0]   m_q;
  bit           m_bits[$];

  sipo_receiver #(.N(N)) dut (
    .Clock(clk), .Resetn(rstn), .Start(start), .En(en), .w(w), .Ack(ack),
    .Q(q), .Valid(valid), .Busy(busy), .Overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rstn) begin
      m_rx = 0; m_hold = 0; m_valid = 0; m_ovr = 0; m_q = '0;
      m_bits.delete();
    end else if (m_hold) begin
      if (ack) begin
        m_valid = 0;
        m_hold  = 0;
        if (start) begin
          m_rx = 1;
          m_bits.delete();
        end
      end else if (start) begin
        m_ovr = 1;
      end
    end else if (m_rx) begin
      if (start) begin
        m_bits.delete();
      end else if (en) begin
        m_bits.push_back(w);
        if (m_bits.size() == N) begin
          for (int i = 0; i < N; i++) m_q[i] = m_bits[i];
          m_valid = 1; m_hold = 1; m_rx = 0;
          m_bits.delete();
        end
      end
    end else if (start) begin
      m_rx = 1;
      m_bits.delete();
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after it.
  task automatic cyc(input logic r, input logic s, input logic e, input logic d, input logic a);
    rstn = r; start = s; en = e; w = d; ack = a;
    @(posedge clk);
    #1;
    cyc_no++;
    model_step();
    chk("q",       32'(q),       32'(m_q));
    chk("valid",   32'(valid),   32'(m_valid));
    chk("busy",    32'(busy),    32'(m_rx | m_hold));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    $display("cyc %0d rstn=%b start=%b en=%b w=%b ack=%b -> q=%b valid=%b busy=%b ovr=%b",
             cyc_no, r, s, e, d, a, q, valid, busy, overrun);
  endtask

  // Send four bits with En=1, b[0] first on the wire.
  task automatic send4(input logic [3:0] b);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, b[i], 0);
  endtask

  initial begin
    rstn = 0; start = 0; en = 0; w = 0; ack = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    // Idle ignores En/w and Ack.
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1);
    chk("idle_busy", 32'(busy), 32'h0);

    // Basic frame: w = 0,1,0,1 -> 1010
    cyc(1, 1, 0, 0, 0);
    chk("t1_busy", 32'(busy), 32'h1);
    cyc(1, 0, 1, 0, 0); cyc(1, 0, 1, 1, 0); cyc(1, 0, 1, 0, 0);
    chk("t1_valid_early", 32'(valid), 32'h0);
    cyc(1, 0, 1, 1, 0);
    chk("t1_q", 32'(q), 32'b1010);
    chk("t1_valid", 32'(valid), 32'h1);
    cyc(1, 0, 1, 0, 0);                // En in HOLD ignored
    chk("t1_hold_q", 32'(q), 32'b1010);
    cyc(1, 0, 0, 0, 1);
    chk("t1_ack_valid", 32'(valid), 32'h0);
    chk("t1_ack_busy", 32'(busy), 32'h0);
    chk("t1_retain_q", 32'(q), 32'b1010);

    // Gap: 1,1, two En=0, 0,0 -> 0011
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0); cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0); cyc(1, 0, 1, 0, 0);
    chk("t2_q", 32'(q), 32'b0011);
    chk("t2_valid", 32'(valid), 32'h1);
    cyc(1, 0, 0, 0, 1);

    // Restart in RECV: 1,1 then Start, then 1,0,1,0 -> 0101, no overrun
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0); cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);                // Start beats En
    send4(4'b0101);
    chk("t6_q", 32'(q), 32'b0101);
    chk("t6_ovr", 32'(overrun), 32'h0);
    cyc(1, 0, 0, 0, 1);

    // Back-to-back: word 1100, then Ack+Start, then 0,1,1,0 -> 0110
    cyc(1, 1, 0, 0, 0);
    send4(4'b1100);
    chk("t4_first_q", 32'(q), 32'b1100);
    cyc(1, 1, 0, 0, 1);
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_valid", 32'(valid), 32'h0);
    send4(4'b0110);
    chk("t4_q", 32'(q), 32'b0110);
    chk("t4_ovr", 32'(overrun), 32'h0);
    cyc(1, 0, 0, 0, 1);

    // Overrun: word 1001 held, Start pulsed while Ack=0
    cyc(1, 1, 0, 0, 0);
    send4(4'b1001);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0);
    chk("t3_ovr", 32'(overrun), 32'h1);
    chk("t3_q", 32'(q), 32'b1001);
    chk("t3_valid", 32'(valid), 32'h1);
    cyc(1, 0, 0, 0, 1);
    chk("t3_ack_valid", 32'(valid), 32'h0);
    chk("t3_ack_ovr", 32'(overrun), 32'h1);

    // Reset mid-frame, then 0,1,1,1 -> 1110
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0); cyc(1, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("t5_q", 32'(q), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_ovr", 32'(overrun), 32'h0);
    cyc(1, 1, 0, 0, 0);
    send4(4'b1110);
    chk("t5_new_q", 32'(q), 32'b1110);
    chk("t5_new_valid", 32'(valid), 32'h1);
    cyc(1, 0, 0, 0, 1);

    // Reset while holding drops Valid.
    cyc(1, 1, 0, 0, 0);
    send4(4'b0111);
    cyc(0, 0, 0, 0, 0);
    chk("t7_valid", 32'(valid), 32'h0);
    cyc(1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
